// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring system datapath.
// Holds bus widths, the serializer state type and elaboration-time helpers.
package continuous_monitoring_system_pkg;

  localparam int AXI_DATA_WIDTH       = 200;
  localparam int SERIALIZER_OUT_WIDTH = 64;

  typedef enum logic {SER_IDLE, SER_SEND} serializer_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all ones; synchronous clear wins over increment.
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/trace_axis_serializer.sv
// Splits one wide trace packet into LSB-first OUT_WIDTH beats on AXI-Stream,
// with zero-bubble back-to-back packets and packet/stall status counters.
module trace_axis_serializer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int IN_WIDTH           = AXI_DATA_WIDTH,
  parameter int OUT_WIDTH          = SERIALIZER_OUT_WIDTH,
  parameter int TLAST_EVERY_PACKET = 0,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]      S_AXIS_tdata,
  input  logic                     S_AXIS_tlast,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [OUT_WIDTH-1:0]     M_AXIS_tdata,
  output logic                     M_AXIS_tlast,
  input  logic                     clear_counters,
  output logic [COUNTER_WIDTH-1:0] packet_count,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic                     busy
);

  localparam int BEATS  = ceil_div(IN_WIDTH, OUT_WIDTH);
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BUF_W  = BEATS * OUT_WIDTH;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

  serializer_state_t        r_state;
  serializer_state_t        w_state_next;
  logic [BUF_W-1:0]         r_buf;
  logic [BIDX_W-1:0]        r_beat_idx;
  logic                     r_pkt_last;
  logic [COUNTER_WIDTH-1:0] r_packet_count;

  logic w_last_beat;
  logic w_s_hs;
  logic w_m_hs;

  assign w_last_beat = (r_beat_idx == LAST_IDX);
  assign w_s_hs      = S_AXIS_tvalid & S_AXIS_tready;
  assign w_m_hs      = M_AXIS_tvalid & M_AXIS_tready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SER_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    S_AXIS_tready = 1'b0;
    M_AXIS_tvalid = 1'b0;
    case (r_state)
      SER_IDLE: begin
        S_AXIS_tready = 1'b1;
        if (S_AXIS_tvalid) w_state_next = SER_SEND;
      end
      SER_SEND: begin
        M_AXIS_tvalid = 1'b1;
        S_AXIS_tready = M_AXIS_tready & w_last_beat;
        if (M_AXIS_tready && w_last_beat && !S_AXIS_tvalid) w_state_next = SER_IDLE;
      end
      default: w_state_next = SER_IDLE;
    endcase
  end

  // NOTE: the beat buffer is reset even though it is datapath, because
  // M_AXIS_tdata is taken straight from it and must read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_beat_idx <= '0;
      r_pkt_last <= 1'b0;
    end else if (w_s_hs) begin
      r_buf      <= BUF_W'(S_AXIS_tdata);
      r_beat_idx <= '0;
      r_pkt_last <= S_AXIS_tlast;
    end else if (w_m_hs && !w_last_beat) begin
      r_buf      <= r_buf >> OUT_WIDTH;
      r_beat_idx <= r_beat_idx + BIDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_packet_count <= '0;
    else if (clear_counters)        r_packet_count <= '0;
    else if (w_m_hs && w_last_beat) r_packet_count <= r_packet_count + COUNTER_WIDTH'(1);
  end

  saturating_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_stall_counter (
    .clk (clk),
    .rst (rst),
    .inc (M_AXIS_tvalid & ~M_AXIS_tready),
    .clr (clear_counters),
    .q   (stall_count)
  );

  assign M_AXIS_tdata = r_buf[OUT_WIDTH-1:0];
  assign M_AXIS_tlast = (r_state == SER_SEND) & w_last_beat &
                        (r_pkt_last | (TLAST_EVERY_PACKET != 0));
  assign packet_count = r_packet_count;
  assign busy         = (r_state == SER_SEND);

endmodule

// File: tb/tb_trace_axis_serializer.sv
// Bench for trace_axis_serializer: two instances (tlast-on-input/32-bit counters and
// tlast-every-packet/3-bit counters) share stimulus and are checked against a beat-queue model.
module tb_trace_axis_serializer;

  localparam int IW = 200;
  localparam int OW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [IW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b1;
  logic          clr = 1'b0;

  logic          s_tready1, m_tvalid1, m_tlast1, busy1;
  logic [OW-1:0] m_tdata1;
  logic [31:0]   pkt1, stall1;
  logic          s_tready2, m_tvalid2, m_tlast2, busy2;
  logic [OW-1:0] m_tdata2;
  logic [2:0]    pkt2, stall2;

  trace_axis_serializer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .TLAST_EVERY_PACKET(0), .COUNTER_WIDTH(32)
  ) dut1 (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready1), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid1), .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata1),
    .M_AXIS_tlast(m_tlast1),
    .clear_counters(clr), .packet_count(pkt1), .stall_count(stall1), .busy(busy1)
  );

  trace_axis_serializer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .TLAST_EVERY_PACKET(1), .COUNTER_WIDTH(3)
  ) dut2 (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready2), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid2), .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata2),
    .M_AXIS_tlast(m_tlast2),
    .clear_counters(clr), .packet_count(pkt2), .stall_count(stall2), .busy(busy2)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending output beats plus counters.
  typedef struct packed {
    logic [63:0] d;
    logic        fin;
    logic        pl;
  } beat_t;

  beat_t       q[$];
  int unsigned m_pkt   = 0;
  int unsigned m_stall = 0;
  int unsigned m_sat3  = 0;

  initial begin
    logic [255:0] padded;
    logic         ev, et;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_pkt = 0; m_stall = 0; m_sat3 = 0;
      end else begin
        ev = (q.size() != 0);
        et = (q.size() == 0) || (q.size() == 1 && m_tready);
        if (ev && !m_tready) begin
          m_stall++;
          if (m_sat3 < 7) m_sat3++;
        end
        if (ev && m_tready) begin
          if (q[0].fin) m_pkt++;
          void'(q.pop_front());
        end
        if (s_tvalid && et) begin
          padded = 256'(s_tdata);
          for (int b = 0; b < 4; b++)
            q.push_back('{d: padded[b*64 +: 64], fin: (b == 3), pl: s_tlast});
        end
        if (clr) begin
          m_pkt = 0; m_stall = 0; m_sat3 = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic ev, et, fin, pl;
    forever begin
      @(negedge clk);
      ev  = (q.size() != 0);
      et  = (q.size() == 0) || (q.size() == 1 && m_tready);
      fin = ev ? q[0].fin : 1'b0;
      pl  = ev ? q[0].pl  : 1'b0;
      check("m_tvalid1", m_tvalid1, ev);
      check("m_tvalid2", m_tvalid2, ev);
      check("s_tready1", s_tready1, et);
      check("s_tready2", s_tready2, et);
      check("busy1", busy1, ev);
      check("busy2", busy2, ev);
      check("m_tlast1", m_tlast1, fin & pl);
      check("m_tlast2", m_tlast2, fin);
      if (ev) begin
        check("m_tdata1", m_tdata1, q[0].d);
        check("m_tdata2", m_tdata2, q[0].d);
      end
      check("packet_count1", pkt1, m_pkt);
      check("packet_count2", pkt2, m_pkt % 8);
      check("stall_count1", stall1, m_stall);
      check("stall_count2", stall2, m_sat3);
    end
  end

  time t_hs;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [IW-1:0] d, input logic last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (s_tready1) break;
    end
    if (n == 64) check("send_timeout", 1, 0);
    @(posedge clk);
    t_hs = $time;
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [IW-1:0]  pat;
    logic [223:0]   rnd;
    logic           hs;
    time            t_a;
    int             nl1, nl2;

    for (int k = 0; k < 25; k++) pat[8*k +: 8] = 8'(k + 1);

    // Reset state
    #2;
    check("rst_tvalid", m_tvalid1, 0);
    check("rst_tdata", m_tdata1, 0);
    check("rst_busy", busy1, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single packet, bytes 0x01..0x19, tlast=1
    send_pkt(pat, 1'b1);
    @(negedge clk);
    check("t1_beat0", m_tdata1, 64'h0807060504030201);
    check("t1_tready_b0", s_tready1, 0);
    @(negedge clk);
    check("t1_beat1", m_tdata1, 64'h100F0E0D0C0B0A09);
    check("t1_tlast_b1", m_tlast1, 0);
    @(negedge clk);
    check("t1_beat2", m_tdata1, 64'h1817161514131211);
    @(negedge clk);
    check("t1_beat3", m_tdata1, 64'h19);
    check("t1_tlast_b3", m_tlast1, 1);
    check("t1_tready_b3", s_tready1, 1);
    @(negedge clk);
    check("t1_pkt_count", pkt1, 1);
    check("t1_idle", busy1, 0);

    // Two back-to-back packets, no bubble
    pulse_clear();
    send_pkt(pat, 1'b1);
    t_a = t_hs;
    send_pkt(~pat, 1'b0);
    check("b2b_spacing", 64'(t_hs - t_a), 64'd40);
    repeat (4) step();
    check("b2b_pkt_count", pkt1, 2);
    check("b2b_idle", busy1, 0);

    // Stall 5 cycles on beat 1
    pulse_clear();
    send_pkt(pat, 1'b1);
    step();
    m_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_data", m_tdata1, 64'h100F0E0D0C0B0A09);
      check("stall_hold_last", m_tlast1, 0);
      @(posedge clk);
    end
    #1;
    m_tready = 1'b1;
    @(negedge clk);
    check("stall_count5", stall1, 5);
    check("stall_beat1_out", m_tdata1, 64'h100F0E0D0C0B0A09);
    repeat (4) step();

    // Input tlast=0: only the every-packet instance flags the final beat
    send_pkt(pat, 1'b0);
    nl1 = 0; nl2 = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_tlast1) nl1++;
      if (m_tlast2) nl2++;
    end
    check("notlast_dut1", 64'(nl1), 0);
    check("notlast_dut2", 64'(nl2), 1);
    step();

    // Async reset during beat 2
    send_pkt(pat, 1'b1);
    step(); step();
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", m_tvalid1, 0);
    check("mid_rst_tdata", m_tdata1, 0);
    check("mid_rst_tlast", m_tlast2, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_pkt", pkt1, 0);
    step(); step();
    rst = 1'b0;
    step();
    send_pkt(~pat, 1'b1);
    @(negedge clk);
    check("post_rst_beat0", m_tdata1, ~64'h0807060504030201);
    repeat (4) step();

    // Stall saturation in the 3-bit instance
    pulse_clear();
    send_pkt(pat, 1'b1);
    m_tready = 1'b0;
    repeat (10) step();
    check("sat_stall_dut1", stall1, 10);
    check("sat_stall_dut2", stall2, 7);
    m_tready = 1'b1;
    repeat (5) step();

    // clear_counters coincident with final-beat handshake
    send_pkt(pat, 1'b1);
    step(); step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_prio_pkt", pkt1, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs = s_tvalid & s_tready1;
      step();
      if (!s_tvalid || hs) begin
        for (int w = 0; w < 7; w++) rnd[w*32 +: 32] = $urandom;
        s_tvalid = ($urandom % 3) != 0;
        s_tdata  = rnd[IW-1:0];
        s_tlast  = $urandom % 2;
      end
      m_tready = ($urandom % 4) != 0;
      clr      = ($urandom % 64) == 0;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    clr      = 1'b0;
    repeat (10) step();
    check("drain_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
